// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave register bank: byte-writable 32-bit control registers with
// independent AW/W acceptance, one outstanding write and one outstanding read.
module axi_lite_slave_regfile #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned C_NUM_REGS         = 16
) (
    input  logic                                      S_AXI_ACLK,
    input  logic                                      S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
    input  logic [2:0]                                S_AXI_AWPROT,
    input  logic                                      S_AXI_AWVALID,
    output logic                                      S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
    input  logic                                      S_AXI_WVALID,
    output logic                                      S_AXI_WREADY,
    output logic [1:0]                                S_AXI_BRESP,
    output logic                                      S_AXI_BVALID,
    input  logic                                      S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
    input  logic [2:0]                                S_AXI_ARPROT,
    input  logic                                      S_AXI_ARVALID,
    output logic                                      S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
    output logic [1:0]                                S_AXI_RRESP,
    output logic                                      S_AXI_RVALID,
    input  logic                                      S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]  o_regs,
    output logic                                      o_wr_pulse,
    output logic [C_S_AXI_ADDR_WIDTH-3:0]             o_wr_index
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IW = AW - 2;
    localparam int unsigned SW = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          rst_done;
    logic          aw_held;
    logic          w_held;
    logic          bvalid;
    logic          rvalid;
    logic [IW-1:0] aw_idx_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;
    logic [1:0]    bresp;
    logic [1:0]    rresp;
    logic [DW-1:0] rdata;
    logic [DW-1:0] regs [C_NUM_REGS];

    logic          aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [DW-1:0] wr_data, rd_val;
    logic [SW-1:0] wr_strb;
    logic          wr_hit, rd_hit;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = rst_done & ~aw_held & ~bvalid;
    assign S_AXI_WREADY  = rst_done & ~w_held & ~bvalid;
    assign S_AXI_ARREADY = rst_done & ~rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign b_hs   = bvalid & S_AXI_BREADY;
    assign r_hs   = rvalid & S_AXI_RREADY;
    assign commit = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid;

    // A held beat always takes precedence over the live bus for its channel.
    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[AW-1:2];
    assign wr_data = w_held ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held ? wstrb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[AW-1:2];

    always_comb begin
        wr_hit = 1'b0;
        rd_hit = 1'b0;
        rd_val = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            if (wr_idx == IW'(i)) wr_hit = 1'b1;
            if (rd_idx == IW'(i)) begin
                rd_hit = 1'b1;
                rd_val = regs[i];
            end
        end
    end

    always_comb begin
        o_regs = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            o_regs[DW*i +: DW] = regs[i];
        end
    end

    // Register storage with per-byte enables.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int unsigned i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
                if (wr_idx == IW'(i)) begin
                    for (int unsigned k = 0; k < SW; k++) begin
                        if (wr_strb[k]) regs[i][8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Write channel bookkeeping and response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rst_done   <= 1'b0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            o_wr_pulse <= 1'b0;
            o_wr_index <= '0;
        end else begin
            rst_done   <= 1'b1;
            o_wr_pulse <= commit;
            if (commit) begin
                aw_held    <= 1'b0;
                w_held     <= 1'b0;
                bvalid     <= 1'b1;
                bresp      <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                o_wr_index <= wr_idx;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[AW-1:2];
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                end
                if (b_hs) bvalid <= 1'b0;
            end
        end
    end

    // Read channel: data captured from pre-write register contents.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_hit ? rd_val : '0;
            rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (r_hs) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Bench for axi_lite_slave_regfile: directed scenarios plus random traffic,
// checked every cycle against a transaction-level register model.
module tb_axi_lite_slave_regfile;

    localparam int unsigned AW = 6;
    localparam int unsigned NR = 8;
    localparam int unsigned FW = NR * 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic [2:0]    awprot = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [FW-1:0] o_regs;
    logic          o_wr_pulse;
    logic [AW-3:0] o_wr_index;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    axi_lite_slave_regfile #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_NUM_REGS(NR)
    ) dut (
        .S_AXI_ACLK(clk),       .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),  .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),  .S_AXI_RREADY(rready),
        .o_regs(o_regs),        .o_wr_pulse(o_wr_pulse), .o_wr_index(o_wr_index)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timeout at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model and per-cycle compare ----------------
    logic [31:0]   m_regs [NR];
    bit            m_valid = 1'b0;
    bit            m_rst_done, m_aw_held, m_w_held, m_bvalid, m_rvalid, m_pulse;
    logic [AW-1:0] m_awaddr;
    logic [31:0]   m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_bresp, m_rresp;
    int            m_index;

    always @(negedge clk) begin
        logic [FW-1:0] exp_flat;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    s;
        int            idx;
        bit            e_awr, e_wr, e_arr, aw_hs, w_hs, ar_hs, commit;
        e_awr = m_rst_done && !m_aw_held && !m_bvalid;
        e_wr  = m_rst_done && !m_w_held && !m_bvalid;
        e_arr = m_rst_done && !m_rvalid;
        if (m_valid) begin
            chk("awready", awready, e_awr);
            chk("wready", wready, e_wr);
            chk("arready", arready, e_arr);
            chk("bvalid", bvalid, m_bvalid);
            chk("rvalid", rvalid, m_rvalid);
            chk("wr_pulse", o_wr_pulse, m_pulse);
            if (m_bvalid) chk("bresp", bresp, m_bresp);
            if (m_rvalid) begin
                chk("rdata", rdata, m_rdata);
                chk("rresp", rresp, m_rresp);
            end
            if (m_pulse) chk("wr_index", o_wr_index, m_index);
            for (int i = 0; i < NR; i++) exp_flat[32*i +: 32] = m_regs[i];
            chk("o_regs", o_regs, exp_flat);
        end
        if (!rstn) begin
            m_valid = 1'b1;
            m_rst_done = 0; m_aw_held = 0; m_w_held = 0; m_bvalid = 0;
            m_rvalid = 0; m_pulse = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
            for (int i = 0; i < NR; i++) m_regs[i] = 0;
        end else begin
            aw_hs  = awvalid && e_awr;
            w_hs   = wvalid && e_wr;
            ar_hs  = arvalid && e_arr;
            commit = (m_aw_held || aw_hs) && (m_w_held || w_hs) && !m_bvalid;
            if (ar_hs) begin
                idx = int'(araddr) / 4;
                m_rvalid = 1;
                m_rdata  = (idx < NR) ? m_regs[idx] : 32'h0;
                m_rresp  = (idx < NR) ? 2'b00 : 2'b10;
            end else if (m_rvalid && rready) begin
                m_rvalid = 0;
            end
            m_pulse = commit;
            if (commit) begin
                a   = m_aw_held ? m_awaddr : awaddr;
                d   = m_w_held ? m_wdata : wdata;
                s   = m_w_held ? m_wstrb : wstrb;
                idx = int'(a) / 4;
                if (idx < NR) begin
                    for (int k = 0; k < 4; k++)
                        if (s[k]) m_regs[idx][8*k +: 8] = d[8*k +: 8];
                end
                m_bresp   = (idx < NR) ? 2'b00 : 2'b10;
                m_bvalid  = 1;
                m_index   = idx;
                m_aw_held = 0;
                m_w_held  = 0;
            end else begin
                if (m_bvalid && bready) m_bvalid = 0;
                if (aw_hs) begin m_aw_held = 1; m_awaddr = awaddr; end
                if (w_hs) begin m_w_held = 1; m_wdata = wdata; m_wstrb = wstrb; end
            end
            m_rst_done = 1;
        end
    end

    // ---------------- channel drivers ----------------
    task automatic aw_send(input logic [AW-1:0] addr, input int dly);
        bit done = 0;
        repeat (dly) step();
        awaddr = addr; awvalid = 1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (awready) done = 1;
            step();
        end
        awvalid = 0;
        if (!done) fail_timeout("aw_wait");
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input int dly);
        bit done = 0;
        repeat (dly) step();
        wdata = data; wstrb = strb; wvalid = 1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (wready) done = 1;
            step();
        end
        wvalid = 0;
        if (!done) fail_timeout("w_wait");
    endtask

    task automatic b_wait();
        bit done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (bvalid && bready) done = 1;
            step();
        end
        if (!done) fail_timeout("b_wait");
    endtask

    task automatic wr_send(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int daw, input int dw);
        fork
            aw_send(addr, daw);
            w_send(data, strb, dw);
        join
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int daw, input int dw);
        wr_send(addr, data, strb, daw, dw);
        b_wait();
    endtask

    task automatic rd(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit done = 0;
        data = '0; resp = '0;
        araddr = addr; arvalid = 1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (arready) done = 1;
            step();
        end
        arvalid = 0;
        if (!done) fail_timeout("ar_wait");
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (rvalid && rready) begin
                done = 1; data = rdata; resp = rresp;
            end
            step();
        end
        if (!done) fail_timeout("r_wait");
    endtask

    initial forever begin
        step();
        if (rand_ready) begin
            bready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d, d2;
        logic [1:0]  r, r2;
        logic [31:0] ra, rdt, rs;

        repeat (3) @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        chk("arready_first_cycle", arready, 0);
        chk("awready_first_cycle", awready, 0);
        @(negedge clk);
        chk("arready_second_cycle", arready, 1);
        step();

        for (int i = 0; i < 16; i++) begin
            rd(AW'(4 * i), d, r);
            chk("reset_rdata", d, 32'h0);
            chk("reset_rresp", r, (i < NR) ? 2'b00 : 2'b10);
        end

        // simultaneous AW + W
        wr_send(6'h08, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("sim_bvalid", bvalid, 1);
        chk("sim_pulse", o_wr_pulse, 1);
        chk("sim_index", o_wr_index, 2);
        chk("sim_reg2", o_regs[95:64], 32'hDEADBEEF);
        chk("sim_bresp", bresp, 2'b00);
        b_wait();

        // W first, AW later, partial strobe
        wr(6'h0C, 32'hAAAAAAAA, 4'hF, 0, 0);
        w_send(32'h12345678, 4'h3, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wready_while_held", wready, 0);
            step();
        end
        aw_send(6'h0C, 0);
        b_wait();
        chk("partial_reg3", o_regs[127:96], 32'hAAAA5678);

        // out-of-range write and read
        wr_send(6'h20, 32'hFFFFFFFF, 4'hF, 1, 0);
        chk("oor_bresp", bresp, 2'b10);
        chk("oor_pulse", o_wr_pulse, 1);
        b_wait();
        rd(6'h3C, d, r);
        chk("oor_rdata", d, 32'h0);
        chk("oor_rresp", r, 2'b10);

        // B stall with a concurrent read
        bready = 0;
        wr_send(6'h10, 32'h55550000, 4'hF, 0, 0);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_bvalid", bvalid, 1);
                    chk("stall_awready", awready, 0);
                    chk("stall_wready", wready, 0);
                end
            end
            begin
                rd(6'h08, d2, r2);
                chk("stall_read", d2, 32'hDEADBEEF);
            end
        join
        step();
        bready = 1;
        b_wait();

        // same-edge write and read of reg1
        fork
            wr(6'h04, 32'h1, 4'hF, 0, 0);
            rd(6'h04, d, r);
        join
        chk("same_edge_old", d, 32'h0);
        rd(6'h04, d, r);
        chk("same_edge_new", d, 32'h1);

        // reset in the middle of a write
        w_send(32'hCAFEF00D, 4'hF, 0);
        rstn = 0;
        step(); step();
        rstn = 1;
        step(); step();
        chk("midreset_regs", o_regs, '0);
        chk("midreset_bvalid", bvalid, 0);
        aw_send(6'h00, 0);
        step();
        @(negedge clk);
        chk("midreset_no_commit", bvalid, 0);
        step();
        w_send(32'h00000011, 4'hF, 0);
        b_wait();
        chk("midreset_reg0", o_regs[31:0], 32'h11);

        // random concurrent traffic with random back-pressure
        rand_ready = 1;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    ra = $urandom; rdt = $urandom; rs = $urandom;
                    wr(ra[AW-1:0], rdt, rs[3:0], $urandom_range(0, 3), $urandom_range(0, 3));
                end
            end
            begin
                for (int n = 0; n < 150; n++) begin
                    ra = $urandom;
                    rd(ra[AW-1:0], d2, r2);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
        join
        rand_ready = 0;
        step();
        bready = 1;
        rready = 1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
